nic_tx: RTL

NIC_TX -- requirements
Module: nic_tx

---
 rtl/noc_pkg.sv | 38 +++
 rtl/nic_tx_flitgen.sv | 25 ++
 rtl/nic_tx.sv | 92 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, type codes and NIC transmit types.
package noc_pkg;

    localparam int unsigned LINK_WIDTH = 8;
    localparam int unsigned TYPE_W     = 2;
    localparam int unsigned PAYLOAD_W  = LINK_WIDTH - TYPE_W;
    localparam int unsigned TYPE_LSB   = PAYLOAD_W;
    localparam int unsigned TYPE_MSB   = LINK_WIDTH - 1;
    localparam int unsigned DEST_W     = 4;
    localparam int unsigned LEN_W      = 2;
    localparam int unsigned MAX_FLITS  = 4;
    localparam int unsigned DATA_W     = PAYLOAD_W * MAX_FLITS;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_BODY = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_TAIL = 2'b10
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2
    } nic_tx_state_e;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] data;
    } pkt_req_t;

    function automatic logic [LINK_WIDTH-1:0] make_flit(input flit_type_e t,
                                                       input logic [PAYLOAD_W-1:0] p);
        return {t, p};
    endfunction

endpackage

// File: rtl/nic_tx_flitgen.sv
// Builds the outgoing flit from FSM state, payload index and latched request.
module nic_tx_flitgen
    import noc_pkg::*;
(
    input  nic_tx_state_e              state,
    input  logic [LEN_W-1:0]           idx,
    input  pkt_req_t                   req,
    output logic [LINK_WIDTH-1:0]      flit_c
);

    logic [PAYLOAD_W-1:0] payload;
    flit_type_e           ptype;

    always_comb begin
        payload = PAYLOAD_W'(req.data >> (PAYLOAD_W * 32'(idx)));
        ptype   = (idx == req.len) ? FLIT_TAIL : FLIT_BODY;
        flit_c  = '0;
        case (state)
            ST_HEAD:    flit_c = make_flit(FLIT_HEAD, {req.dest, req.len});
            ST_PAYLOAD: flit_c = make_flit(ptype, payload);
            default:    flit_c = '0;
        endcase
    end

endmodule

// File: rtl/nic_tx.sv
// NIC transmit side: packetises a request into head/body/tail flits for the local router port.
module nic_tx #(
    parameter int unsigned LINK_WIDTH = 8,
    parameter int unsigned MESH_DIM   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pkt_valid,
    output logic                                 pkt_ready,
    input  logic [$clog2(MESH_DIM*MESH_DIM)-1:0] pkt_dest,
    input  logic [noc_pkg::LEN_W-1:0]            pkt_len,
    input  logic [noc_pkg::DATA_W-1:0]           pkt_data,
    output logic [LINK_WIDTH-1:0]                tx_flit,
    output logic                                 tx_wr_en,
    input  logic                                 tx_full,
    output logic                                 busy,
    output logic [noc_pkg::CNT_W-1:0]            pkt_sent_cnt
);

    import noc_pkg::nic_tx_state_e;
    import noc_pkg::ST_IDLE;
    import noc_pkg::ST_HEAD;
    import noc_pkg::ST_PAYLOAD;
    import noc_pkg::pkt_req_t;
    import noc_pkg::LEN_W;
    import noc_pkg::CNT_W;

    nic_tx_state_e    state;
    pkt_req_t         req;
    logic [LEN_W-1:0] idx;
    logic             wr_en_q;

    // Writing at most every other cycle keeps the one-cycle-stale full flag safe.
    assign tx_wr_en = (state != ST_IDLE) & ~tx_full & ~wr_en_q;

    nic_tx_flitgen u_flitgen (
        .state  (state),
        .idx    (idx),
        .req    (req),
        .flit_c (tx_flit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            req          <= '0;
            idx          <= '0;
            wr_en_q      <= 1'b0;
            pkt_ready    <= 1'b0;
            busy         <= 1'b0;
            pkt_sent_cnt <= '0;
        end else begin
            wr_en_q <= tx_wr_en;
            case (state)
                ST_IDLE: begin
                    pkt_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (pkt_valid && pkt_ready) begin
                        req       <= '{dest: pkt_dest, len: pkt_len, data: pkt_data};
                        state     <= ST_HEAD;
                        pkt_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_HEAD: begin
                    if (tx_wr_en) begin
                        state <= ST_PAYLOAD;
                        idx   <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (tx_wr_en) begin
                        if (idx == req.len) begin
                            state        <= ST_IDLE;
                            pkt_ready    <= 1'b1;
                            busy         <= 1'b0;
                            pkt_sent_cnt <= pkt_sent_cnt + CNT_W'(1);
                        end else begin
                            idx <= idx + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pkt_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
